// File: rtl/prefetch_unit.sv
// Instruction prefetch unit: issues sequential word fetches over a split
// request/response memory handshake and queues up to DEPTH instructions,
// each tagged with its PC and abort status, for the decode stage.
//
// Handshakes: a request transfers when mem_req && mem_gnt; its single
// response arrives later as mem_rvalid. A queue entry transfers to decode
// when instr_valid && instr_ready. Only one request is ever outstanding,
// and a request is issued only when the queue has space for its response.
module prefetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                       clk,
  input  logic                       n_reset,
  output logic                       mem_req,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  input  logic                       mem_gnt,
  input  logic                       mem_rvalid,
  input  logic [DATA_WIDTH-1:0]      mem_rdata,
  input  logic                       mem_abort,
  input  logic                       flush,
  input  logic [ADDR_WIDTH-1:0]      flush_pc,
  output logic                       instr_valid,
  output logic [DATA_WIDTH-1:0]      instr,
  output logic [ADDR_WIDTH-1:0]      instr_pc,
  output logic                       instr_abort,
  input  logic                       instr_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [1:0]                 dbg_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] req_pc;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  logic [DATA_WIDTH-1:0] data_q  [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_q    [DEPTH];
  logic                  abort_q [DEPTH];

  logic grant;
  logic push;
  logic pop;

  // Request depends only on registered state so flush never gates it.
  assign mem_req  = n_reset && (state == ST_IDLE) && (count < CNT_W'(DEPTH));
  assign mem_addr = fetch_pc;
  assign grant    = mem_req && mem_gnt;
  // Flush discards both a same-cycle response and a same-cycle pop.
  assign push     = (state == ST_WAIT) && mem_rvalid && !flush;
  assign pop      = instr_valid && instr_ready && !flush;

  assign instr_valid = (count != '0);
  assign instr       = data_q[rd_ptr];
  assign instr_pc    = pc_q[rd_ptr];
  assign instr_abort = abort_q[rd_ptr];
  assign dbg_state   = state;

  // Next-state logic; flush overrides every other event.
  always_comb begin
    state_next = state;
    if (flush) begin
      case (state)
        ST_IDLE: state_next = grant ? ST_DROP : ST_IDLE;
        ST_WAIT: state_next = mem_rvalid ? ST_IDLE : ST_DROP;
        ST_DROP: state_next = mem_rvalid ? ST_IDLE : ST_DROP;
        ST_HALT: state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end else begin
      case (state)
        ST_IDLE: if (grant)      state_next = ST_WAIT;
        ST_WAIT: if (mem_rvalid) state_next = mem_abort ? ST_HALT : ST_IDLE;
        ST_DROP: if (mem_rvalid) state_next = ST_IDLE;
        ST_HALT: state_next = ST_HALT;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Fetch address: redirect on flush, advance (wrapping) on each grant.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
    end else begin
      if (grant) req_pc <= fetch_pc;
      if (flush)      fetch_pc <= flush_pc;
      else if (grant) fetch_pc <= fetch_pc + ADDR_WIDTH'(1);
    end
  end

  // Circular queue pointers and occupancy; flush empties the queue.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Queue storage; cleared on reset so the head outputs start at zero.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i]  <= '0;
        pc_q[i]    <= '0;
        abort_q[i] <= 1'b0;
      end
    end else if (push) begin
      data_q[wr_ptr]  <= mem_rdata;
      pc_q[wr_ptr]    <= req_pc;
      abort_q[wr_ptr] <= mem_abort;
    end
  end

endmodule

// File: tb/tb_prefetch_unit.sv
// Bench for prefetch_unit: a randomized memory responder plus a
// transaction-level reference of the fetch stream (next PC, one
// outstanding request, halted flag, queue of expected entries).
module tb_prefetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0, mem_abort = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        instr_ready = 1'b0;

  logic        mem_req, instr_valid, instr_abort;
  logic [31:0] mem_addr, instr, instr_pc;
  logic [2:0]  count;
  logic [1:0]  dbg_state;

  logic        mem_req2, instr_valid2, instr_abort2;
  logic [31:0] mem_addr2, instr2, instr_pc2;
  logic [2:0]  count2;
  logic [1:0]  dbg_state2;

  // clock
  always #5 clk = ~clk;

  prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .n_reset(n_reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_abort(mem_abort), .flush(flush), .flush_pc(flush_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_abort(instr_abort), .instr_ready(instr_ready), .count(count),
    .dbg_state(dbg_state)
  );

  prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFF)) dut_wrap (
    .clk(clk), .n_reset(n_reset), .mem_req(mem_req2), .mem_addr(mem_addr2),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_abort(mem_abort), .flush(flush), .flush_pc(flush_pc),
    .instr_valid(instr_valid2), .instr(instr2), .instr_pc(instr_pc2),
    .instr_abort(instr_abort2), .instr_ready(instr_ready), .count(count2),
    .dbg_state(dbg_state2)
  );

  int errors = 0;
  int checks = 0;

  // reference model: entry = {data[64:33], pc[32:1], abort[0]}
  logic [64:0] exp_q[$];
  logic [31:0] m_pc = 32'h0;
  logic [31:0] out_pc = 32'h0;
  bit          out_busy = 0, out_drop = 0, halted = 0;

  // memory responder
  bit          mem_busy = 0;
  int          mem_wait = 0;
  logic [31:0] mem_a = '0;
  int          gnt_pct = 100, lat_min = 0, lat_max = 0, abort_pct = 0;
  bit          abort_en = 0, force_rv = 0;
  logic [31:0] abort_addr = '0;

  // logs
  logic [31:0] grant_log[$];
  logic [31:0] grant_log2[$];
  logic [64:0] pop_log[$];
  int          max_count = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expected);
    checks++;
    assert (obs === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expected);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pc = 32'h0; out_busy = 0; out_drop = 0; halted = 0;
    mem_busy = 0; mem_wait = 0;
  endtask

  // One clock cycle: check outputs against the model, drive inputs,
  // then advance the model with the events of this cycle.
  task automatic tick(input bit fl, input logic [31:0] fpc, input bit rdy);
    bit          exp_req, rv, gnt, ab, grant_m, rv_m, pop_m;
    logic [31:0] rd;
    @(negedge clk);
    exp_req = !out_busy && !halted && (exp_q.size() < DEPTH);
    chk("mem_req", mem_req, exp_req);
    if (exp_req) chk("mem_addr", mem_addr, m_pc);
    chk("instr_valid", instr_valid, exp_q.size() != 0);
    chk("count", count, exp_q.size());
    if (int'(count) > max_count) max_count = int'(count);
    if (exp_q.size() != 0) begin
      chk("instr", instr, exp_q[0][64:33]);
      chk("instr_pc", instr_pc, exp_q[0][32:1]);
      chk("instr_abort", instr_abort, exp_q[0][0]);
    end
    rv  = force_rv || (mem_busy && mem_wait == 0);
    rd  = mem_a + 32'h100;
    ab  = rv && ((abort_en && mem_a == abort_addr) || ($urandom_range(99) < abort_pct));
    gnt = ($urandom_range(99) < gnt_pct);
    mem_gnt = gnt; mem_rvalid = rv; mem_rdata = rd; mem_abort = ab;
    flush = fl; flush_pc = fpc; instr_ready = rdy;
    if (mem_req && gnt)  grant_log.push_back(mem_addr);
    if (mem_req2 && gnt) grant_log2.push_back(mem_addr2);
    if (rv) mem_busy = 0;
    else if (mem_busy) mem_wait--;
    if (mem_req && gnt) begin
      mem_busy = 1; mem_a = mem_addr; mem_wait = $urandom_range(lat_max, lat_min);
    end
    force_rv = 0;
    grant_m = exp_req && gnt;
    rv_m    = rv && out_busy;
    pop_m   = (exp_q.size() != 0) && rdy;
    if (fl) begin
      exp_q.delete();
      halted = 0;
      m_pc = fpc;
      if (rv_m) out_busy = 0;
      else if (grant_m) begin out_busy = 1; out_drop = 1; end
      else if (out_busy) out_drop = 1;
    end else begin
      if (pop_m) begin
        pop_log.push_back(exp_q[0]);
        void'(exp_q.pop_front());
      end
      if (rv_m) begin
        if (!out_drop) begin
          exp_q.push_back({rd, out_pc, ab});
          if (ab) halted = 1;
        end
        out_busy = 0;
      end
      if (grant_m) begin
        out_busy = 1; out_drop = 0; out_pc = m_pc; m_pc = m_pc + 32'h1;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_instr_valid"}, instr_valid, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_instr"}, instr, 0);
    chk({tag, "_instr_pc"}, instr_pc, 0);
    chk({tag, "_instr_abort"}, instr_abort, 0);
  endtask

  initial begin
    bit found;
    int base;

    // reset
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    chk("rst_req_wrap", mem_req2, 0);
    @(posedge clk); #1 n_reset = 1'b1;

    // fill with zero-wait memory, decode stalled
    gnt_pct = 100; lat_min = 0; lat_max = 0;
    repeat (12) tick(0, 0, 0);
    chk("fill_grants", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) chk("fill_grant_addr", grant_log[i], i);
    chk("fill_count", count, 4);
    chk("fill_no_req", mem_req, 0);
    chk("fill_head_instr", instr, 32'h100);
    chk("fill_head_pc", instr_pc, 0);
    chk("wrap_grants", grant_log2.size() >= 2, 1);
    if (grant_log2.size() >= 2) begin
      chk("wrap_first_addr", grant_log2[0], 32'hFFFF_FFFF);
      chk("wrap_second_addr", grant_log2[1], 32'h0);
    end

    // drain with decode always ready
    repeat (30) tick(0, 0, 1);
    chk("drain_pops", pop_log.size() >= 10, 1);
    for (int i = 0; i < pop_log.size(); i++) chk("drain_pc_order", pop_log[i][32:1], i);
    chk("drain_count_max", max_count <= DEPTH, 1);

    // flush in the cycle after the grant of address 5, late response
    lat_min = 3; lat_max = 3;
    tick(1, 32'h0, 1);
    grant_log.delete();
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick(0, 0, 1);
      if (grant_log.size() != 0 && grant_log[$] == 32'h5) found = 1;
    end
    chk("flush_saw_grant5", found, 1);
    tick(1, 32'h40, 1);
    grant_log.delete(); pop_log.delete();
    repeat (20) tick(0, 0, 1);
    chk("flush_grant_seen", grant_log.size() != 0, 1);
    if (grant_log.size() != 0) chk("flush_next_grant", grant_log[0], 32'h40);
    chk("flush_pop_seen", pop_log.size() != 0, 1);
    if (pop_log.size() != 0) chk("flush_first_pc", pop_log[0][32:1], 32'h40);

    // abort on the response for address 2
    lat_min = 0; lat_max = 0; abort_en = 1; abort_addr = 32'h2;
    tick(1, 32'h0, 1);
    pop_log.delete();
    repeat (15) tick(0, 0, 1);
    chk("abort_pops", pop_log.size(), 3);
    if (pop_log.size() == 3) begin
      chk("abort_pc", pop_log[2][32:1], 2);
      chk("abort_flag", pop_log[2][0], 1);
      chk("abort_prev_flag", pop_log[1][0], 0);
    end
    base = grant_log.size();
    repeat (20) tick(0, 0, 1);
    chk("halt_no_grant", grant_log.size(), base);
    chk("halt_req", mem_req, 0);
    abort_en = 0;
    tick(1, 32'h10, 1);
    grant_log.delete();
    repeat (4) tick(0, 0, 1);
    chk("resume_grant_seen", grant_log.size() != 0, 1);
    if (grant_log.size() != 0) chk("resume_addr", grant_log[0], 32'h10);

    // randomized traffic
    gnt_pct = 70; lat_min = 0; lat_max = 3; abort_pct = 3;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(99) < 4) tick(1, $urandom, $urandom_range(1));
      else                        tick(0, 0, $urandom_range(1));
    end
    abort_pct = 0;

    // reset while a request is outstanding
    gnt_pct = 100; lat_min = 6; lat_max = 6;
    tick(1, 32'h200, 0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(0, 0, 0);
      if (mem_busy && mem_wait >= 2) found = 1;
    end
    chk("rst_wait_reached", found, 1);
    #2 n_reset = 1'b0;
    #1 check_reset_outputs("rst_mid");
    mem_gnt = 0; mem_rvalid = 0; flush = 0; instr_ready = 0;
    model_reset();
    @(posedge clk); @(posedge clk); #1 n_reset = 1'b1;
    gnt_pct = 0; force_rv = 1;
    tick(0, 0, 0);
    tick(0, 0, 0);
    chk("rst_stale_count", count, 0);
    gnt_pct = 100; lat_min = 0; lat_max = 0;
    grant_log.delete();
    repeat (4) tick(0, 0, 0);
    chk("rst_restart_seen", grant_log.size() != 0, 1);
    if (grant_log.size() != 0) chk("rst_restart_addr", grant_log[0], 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prefetch_unit.md
# prefetch_unit

Parametrised instruction prefetch unit that supersedes the single-register fetch stage. It sits between the memory controller and the decode stage. It issues sequential word-addressed fetches through a split request/response memory handshake and buffers up to DEPTH instructions in an in-order queue, each tagged with its PC and abort status. A branch flush discards queued and in-flight fetches and redirects fetching to a new PC.

## Interface
- ADDR_WIDTH, 32, PC and memory address width (word addresses).
- DATA_WIDTH, 32, instruction width.
- DEPTH, 4, queue entries; power of two, at least 2.
- RESET_PC, 0, first fetch address after reset.
- clk  input  1  clock; all state changes on the rising edge.
- n_reset  input  1  asynchronous, active-low reset.
- mem_req  output  1  fetch request valid.
- mem_addr  output  ADDR_WIDTH  fetch address; equals fetch_pc.
- mem_gnt  input  1  request accepted this cycle (mem_req && mem_gnt).
- mem_rvalid  input  1  response for the outstanding request.
- mem_rdata  input  DATA_WIDTH  response data.
- mem_abort  input  1  response is a prefetch abort; qualified by mem_rvalid.
- flush  input  1  redirect request.
- flush_pc  input  ADDR_WIDTH  new fetch address.
- instr_valid  output  1  queue head valid.
- instr  output  DATA_WIDTH  queue head data.
- instr_pc  output  ADDR_WIDTH  queue head address.
- instr_abort  output  1  queue head abort flag.
- instr_ready  input  1  decode consumes head (pop = instr_valid && instr_ready).
- count  output  $clog2(DEPTH+1)  occupied entries.

## Operation
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: request granted, awaiting response.
  - DROP: outstanding response must be discarded.
  - HALT: an abort was queued; no further fetch.
- mem_req = (state==IDLE) && (count < DEPTH), from registered state only; flush does not gate it combinationally. Forced 0 while n_reset low.
- Only one request is outstanding at a time. Credit rule: a request is issued only when the queue has space, so a push never meets a full queue.
- Grant in IDLE:
  - req_pc <= fetch_pc.
  - fetch_pc <= fetch_pc + 1, modulo 2^ADDR_WIDTH.
  - Next state WAIT.
- mem_rvalid in WAIT:
  - Push {mem_rdata, req_pc, mem_abort}.
  - Next state HALT if mem_abort, else IDLE.
- mem_rvalid in DROP: data discarded, next state IDLE.
- mem_rvalid in IDLE or HALT: ignored.
- Flush, which has priority over all other events in the same cycle:
  - Queue emptied; count <= 0; fetch_pc <= flush_pc.
  - A pop in the same cycle is discarded.
  - A response arriving in the same cycle is discarded.
  - State transitions on flush:
    - IDLE with a grant in the same cycle: DROP, because the granted old-address request is in flight.
    - IDLE otherwise: IDLE.
    - WAIT: DROP if no rvalid this cycle, IDLE if rvalid this cycle.
    - DROP: stays DROP (IDLE if rvalid this cycle).
    - HALT: IDLE.
- Queue: circular buffer with rd/wr pointers of log2(DEPTH) bits that wrap naturally.
  - count increments on push and decrements on pop; a simultaneous push and pop leaves it unchanged.
  - instr, instr_pc and instr_abort are driven from the head entry. They are don't-care when instr_valid=0.
- An aborted entry is delivered like any other entry. Decode raises the exception; fetching resumes only after flush.

## Timing
- Reset values (asynchronous):
  - state IDLE, fetch_pc RESET_PC, count 0, pointers 0.
  - instr_valid 0, mem_req 0.
  - instr, instr_pc and instr_abort 0.
- First mem_req occurs in the first cycle after n_reset rises, with mem_addr=RESET_PC.
- mem_rvalid is legal no earlier than the cycle after the grant.
- Pushed entry is visible at instr_valid the cycle after mem_rvalid.
- Peak throughput: 1 instruction per 2 cycles with zero-wait memory (grant, response, repeat).
- Flush in cycle N:
  - instr_valid=0 in cycle N+1.
  - If the state after flush is IDLE, mem_req with mem_addr=flush_pc in cycle N+1.
  - In DROP, the request for flush_pc starts the cycle after the stale rvalid.
- mem_addr is held stable while mem_req is high and ungranted.
- Reset mid-WAIT abandons the request; a late rvalid after reset arrives in IDLE and is ignored.

## Test plan
- Reset, RESET_PC=0, DEPTH=4, zero-wait memory returning rdata=addr+0x100, instr_ready=0:
  - Grants at addresses 0,1,2,3.
  - count reaches 4, then mem_req stays 0.
  - Head is instr=0x100, instr_pc=0.
- Continue scenario 1 with instr_ready=1 held:
  - Pops deliver pc 0,1,2,3,4,5… in order, with no gaps or duplicates.
  - count never exceeds 4.
- Flush with flush_pc=0x40 in the cycle after the grant of address 5; memory returns rvalid 3 cycles later:
  - The response is dropped.
  - The next grant is at 0x40.
  - The first instr_pc after flush is 0x40.
- mem_abort=1 on the response for address 2:
  - Entry pc=2 popped with instr_abort=1.
  - mem_req stays 0 for 20 cycles.
  - Flush to 0x10 then resumes fetching at 0x10.
- RESET_PC=0xFFFF_FFFF: first fetch at 0xFFFF_FFFF, second at 0x0000_0000.
- Assert n_reset low in WAIT, then deliver rvalid after release:
  - All outputs go to reset values immediately.
  - The stale rvalid is ignored (count stays 0).
  - The fetch restarts at RESET_PC.
